// File: rtl/mem_port_arb_if.sv
// rtl/mem_port_arb_if.sv - requester and memory bus bundle for mem_port_arb
//
// Purpose: groups the requester-side and memory-side signals of the port
// arbiter into one bundle.
// Modports:
//   slave  - arbiter view: requests and memory read returns in; grants,
//            read routing, memory access and error flag out.
//   master - environment view (engines plus memory model), the mirror image.
interface mem_port_arb_if #(
  parameter int N_REQ  = 4,
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*MEM_AW-1:0] req_addr;
  logic [N_REQ*MEM_DW-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rd_vld;
  logic [MEM_DW-1:0]       rd_data;
  logic                    mem_req;
  logic                    mem_write;
  logic [MEM_AW-1:0]       mem_addr;
  logic [MEM_DW-1:0]       mem_wdata;
  logic                    mem_rdata_vld;
  logic [MEM_DW-1:0]       mem_rdata;
  logic                    err;

  modport slave (
    input  req, req_write, req_addr, req_wdata, mem_rdata_vld, mem_rdata,
    output gnt, rd_vld, rd_data, mem_req, mem_write, mem_addr, mem_wdata, err
  );

  modport master (
    output req, req_write, req_addr, req_wdata, mem_rdata_vld, mem_rdata,
    input  gnt, rd_vld, rd_data, mem_req, mem_write, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - round-robin arbiter for one shared memory port
//
// Purpose: grants the memory port to one requester per burst (round robin),
// registers the owner's access onto the memory side, tags issued reads in an
// in-order FIFO and routes returning read data back to the issuer.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - mem_port_arb_if.slave: req/req_write/req_addr/req_wdata in,
//         gnt/rd_vld/rd_data out, mem_req/mem_write/mem_addr/mem_wdata out,
//         mem_rdata_vld/mem_rdata in, err out (sticky stray-return flag)
module mem_port_arb #(
  parameter int N_REQ     = 4,
  parameter int MEM_AW    = 16,
  parameter int MEM_DW    = 32,
  parameter int TAG_DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  mem_port_arb_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int OW = PW + 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state;
  logic [IW-1:0]     own;
  logic [IW-1:0]     last;
  logic [N_REQ-1:0]  gnt_q;

  logic              mem_req_q;
  logic              mem_write_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [MEM_DW-1:0] mem_wdata_q;
  logic              err_q;

  logic [IW-1:0]     tag_mem [TAG_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     occ;

  // Returns {found, index}: first set bit of r among the span entries
  // starting at from (modulo N_REQ). Iterating downward lets the lowest
  // offset overwrite the others.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input int from, input int span);
    logic [IW:0] res;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i < span && r[(from + i) % N_REQ]) begin
        res = {1'b1, IW'((from + i) % N_REQ)};
      end
    end
    return res;
  endfunction

  logic [IW:0] pick_idle;
  logic [IW:0] pick_hand;
  assign pick_idle = rr_pick(bus.req, int'(last) + 1, N_REQ);
  // Handover search skips the releasing owner by covering only N_REQ-1 slots.
  assign pick_hand = rr_pick(bus.req, int'(own) + 1, N_REQ - 1);

  logic issue;
  logic issue_rd;
  logic push;
  logic pop;
  assign issue    = bus.req[own] & gnt_q[own];
  assign issue_rd = issue & ~bus.req_write[own];
  assign push     = mem_req_q & ~mem_write_q;
  assign pop      = bus.mem_rdata_vld & (occ != '0);

  // Stall looks one cycle ahead: next occupancy plus a read issued now, which
  // will sit in the output register next cycle and is pushed a cycle later.
  logic [OW-1:0] occ_nx;
  logic [OW:0]   inflight;
  logic          stall_nx;
  assign occ_nx   = occ + OW'(push) - OW'(pop);
  assign inflight = {1'b0, occ_nx} + (OW+1)'(issue_rd);
  assign stall_nx = inflight >= (OW+1)'(TAG_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own   <= '0;
      last  <= IW'(N_REQ - 1);
      gnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[IW]) begin
            state <= OWN;
            own   <= pick_idle[IW-1:0];
            gnt_q <= stall_nx ? '0 : (N_REQ'(1) << pick_idle[IW-1:0]);
          end else begin
            gnt_q <= '0;
          end
        end
        OWN: begin
          if (bus.req[own]) begin
            gnt_q <= stall_nx ? '0 : (N_REQ'(1) << own);
          end else begin
            last <= own;
            if (pick_hand[IW]) begin
              own   <= pick_hand[IW-1:0];
              gnt_q <= stall_nx ? '0 : (N_REQ'(1) << pick_hand[IW-1:0]);
            end else begin
              state <= IDLE;
              gnt_q <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Issue register: memory side holds its last access when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_req_q <= issue;
      if (issue) begin
        mem_write_q <= bus.req_write[own];
        mem_addr_q  <= bus.req_addr[own*MEM_AW +: MEM_AW];
        mem_wdata_q <= bus.req_wdata[own*MEM_DW +: MEM_DW];
      end
    end
  end

  // Read-tag FIFO; the push tag is the current owner, which cannot have
  // changed since the issuing cycle because handover needs an idle cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= own;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_nx;
      if (bus.mem_rdata_vld && occ == '0) err_q <= 1'b1;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rd_vld    = pop ? (N_REQ'(1) << tag_mem[rd_ptr]) : '0;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;
endmodule
